// File: rtl/otter_control_unit.sv
// Multi-cycle control unit for the OTTER RV32I core: sequences FETCH/EXEC/WRITEBACK/INTR
// and decodes the registered instruction into datapath selects and strobes.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_FETCH | instruction read from memory port 1
//   ST_EXEC  | decode IR, update PC, complete every opcode except loads
//   ST_WB    | load data from memory port 2 written into the register file
//   ST_INTR  | interrupt entry: PC <- mtvec, mepc saved, mie cleared
module otter_control_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IR,
    input  logic        INTR,
    input  logic        BR_EQ,
    input  logic        BR_LT,
    input  logic        BR_LTU,
    output logic        PC_WRITE,
    output logic [2:0]  PC_SOURCE,
    output logic        REG_WRITE,
    output logic [1:0]  RF_WR_SEL,
    output logic [3:0]  ALU_FUN,
    output logic        ALU_SRCA,
    output logic [1:0]  ALU_SRCB,
    output logic        MEM_RDEN1,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic        CSR_WE,
    output logic        INT_TAKEN,
    output logic        MRET_EXEC
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WB    = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] PCS_PC4    = 3'd0;
    localparam logic [2:0] PCS_JALR   = 3'd1;
    localparam logic [2:0] PCS_BRANCH = 3'd2;
    localparam logic [2:0] PCS_JAL    = 3'd3;
    localparam logic [2:0] PCS_MTVEC  = 3'd4;
    localparam logic [2:0] PCS_MEPC   = 3'd5;

    localparam logic [1:0] WR_PC4  = 2'd0;
    localparam logic [1:0] WR_CSR  = 2'd1;
    localparam logic [1:0] WR_MEM  = 2'd2;
    localparam logic [1:0] WR_ALU  = 2'd3;

    state_t state_q;
    state_t state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       br_taken;
    logic       ir_unused;

    assign opcode = IR[6:0];
    assign funct3 = IR[14:12];

    // Register specifiers are consumed by the register file directly, not here.
    assign ir_unused = ^{IR[19:15], IR[11:7]};

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = BR_EQ;
            3'b001:  br_taken = ~BR_EQ;
            3'b100:  br_taken = BR_LT;
            3'b101:  br_taken = ~BR_LT;
            3'b110:  br_taken = BR_LTU;
            3'b111:  br_taken = ~BR_LTU;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        PC_WRITE  = 1'b0;
        PC_SOURCE = PCS_PC4;
        REG_WRITE = 1'b0;
        RF_WR_SEL = WR_PC4;
        ALU_FUN   = 4'b0000;
        ALU_SRCA  = 1'b0;
        ALU_SRCB  = 2'd0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        CSR_WE    = 1'b0;
        INT_TAKEN = 1'b0;
        MRET_EXEC = 1'b0;

        case (state_q)
            ST_FETCH: begin
                MEM_RDEN1 = 1'b1;
                state_d   = ST_EXEC;
            end

            ST_EXEC: begin
                PC_WRITE = 1'b1;
                state_d  = INTR ? ST_INTR : ST_FETCH;
                case (opcode)
                    OPC_LUI: begin
                        ALU_SRCA  = 1'b1;
                        ALU_FUN   = 4'b1001;
                        REG_WRITE = 1'b1;
                        RF_WR_SEL = WR_ALU;
                    end
                    OPC_AUIPC: begin
                        ALU_SRCA  = 1'b1;
                        ALU_SRCB  = 2'd3;
                        REG_WRITE = 1'b1;
                        RF_WR_SEL = WR_ALU;
                    end
                    OPC_JAL: begin
                        PC_SOURCE = PCS_JAL;
                        REG_WRITE = 1'b1;
                        RF_WR_SEL = WR_PC4;
                    end
                    OPC_JALR: begin
                        PC_SOURCE = PCS_JALR;
                        REG_WRITE = 1'b1;
                        RF_WR_SEL = WR_PC4;
                    end
                    OPC_BRANCH: begin
                        PC_SOURCE = br_taken ? PCS_BRANCH : PCS_PC4;
                    end
                    OPC_LOAD: begin
                        ALU_SRCB  = 2'd1;
                        MEM_RDEN2 = 1'b1;
                        // Interrupts wait until the load has written back.
                        state_d   = ST_WB;
                    end
                    OPC_STORE: begin
                        ALU_SRCB = 2'd2;
                        MEM_WE2  = 1'b1;
                    end
                    OPC_OP: begin
                        ALU_FUN   = {IR[30], funct3};
                        REG_WRITE = 1'b1;
                        RF_WR_SEL = WR_ALU;
                    end
                    OPC_OP_IMM: begin
                        // Bit 30 selects srai only; for other immediates it is just data.
                        ALU_FUN   = (funct3 == 3'b101) ? {IR[30], funct3} : {1'b0, funct3};
                        ALU_SRCB  = 2'd1;
                        REG_WRITE = 1'b1;
                        RF_WR_SEL = WR_ALU;
                    end
                    OPC_SYSTEM: begin
                        if (funct3 == 3'b001) begin
                            CSR_WE    = 1'b1;
                            REG_WRITE = 1'b1;
                            RF_WR_SEL = WR_CSR;
                        end else if (funct3 == 3'b000 && IR[31:20] == 12'h302) begin
                            PC_SOURCE = PCS_MEPC;
                            MRET_EXEC = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            ST_WB: begin
                REG_WRITE = 1'b1;
                RF_WR_SEL = WR_MEM;
                state_d   = INTR ? ST_INTR : ST_FETCH;
            end

            ST_INTR: begin
                PC_WRITE  = 1'b1;
                PC_SOURCE = PCS_MTVEC;
                INT_TAKEN = 1'b1;
                state_d   = ST_FETCH;
            end

            default: state_d = ST_FETCH;
        endcase

        // Reset aborts whatever is in flight: no strobe may reach the datapath.
        if (RST) begin
            PC_WRITE  = 1'b0;
            PC_SOURCE = PCS_PC4;
            REG_WRITE = 1'b0;
            RF_WR_SEL = WR_PC4;
            ALU_FUN   = 4'b0000;
            ALU_SRCA  = 1'b0;
            ALU_SRCB  = 2'd0;
            MEM_RDEN1 = 1'b0;
            MEM_RDEN2 = 1'b0;
            MEM_WE2   = 1'b0;
            CSR_WE    = 1'b0;
            INT_TAKEN = 1'b0;
            MRET_EXEC = 1'b0;
        end
    end

endmodule
